fetch_unit: RTL
===============

# fetch_unit

Instruction-fetch stage and IF/ID pipeline register of the Osiris I core; the consumer of the hazard unit's `o_stall_IF`, `o_stall_ID` and `o_flush_ID`, and of the EX-stage branch redirect.
- Owns the fetch PC and drives a req/ack instruction-memory port.
- Buffers an instruction that returns while the pipeline is stalled.
- Discards in-flight fetches on a redirect.
- Presents `{instr, pc, pc+4, valid}` to the decode stage.

## Interface
Parameters:
- `DATA_WIDTH`, 32, instruction and address width.
- `RESET_PC`, 32'h0000_0000, first fetch address after reset.

Ports:
- `i_clk`  in  1  core clock; all state on the rising edge.
- `i_rst_n`  in  1  reset; asynchronous, active-low.
- `i_stall_IF`  in  1  hold fetch PC; from the hazard unit.
- `i_stall_ID`  in  1  hold the IF/ID register; from the hazard unit.
- `i_flush_ID`  in  1  load a bubble into IF/ID; from the hazard unit.
- `i_pcSrc_EX`  in  1  taken branch or jump resolved in EX.
- `i_pc_target_EX`  in  DATA_WIDTH  redirect target; valid when `i_pcSrc_EX`=1.
- `o_imem_req`  out  1  fetch request.
- `o_imem_addr`  out  DATA_WIDTH  fetch address; word-aligned.
- `i_imem_ack`  in  1  response valid; may arrive in the same cycle as the request.
- `i_imem_rdata`  in  DATA_WIDTH  instruction; valid when `i_imem_ack`=1.
- `o_instr_ID`  out  DATA_WIDTH  IF/ID instruction.
- `o_pc_ID`  out  DATA_WIDTH  IF/ID PC.
- `o_pc_plus4_ID`  out  DATA_WIDTH  IF/ID PC+4.
- `o_valid_ID`  out  1  IF/ID holds a real instruction.

## Operation
- Registers:
  - `pc_F`.
  - `redir_pc` (redirect target saved while a fetch is in flight).
  - Skid buffer `buf_instr` and `buf_pc`.
  - FSM in {FETCH, BUFFERED, DROP}.
  - IF/ID register.
- Outputs from state:
  - `o_imem_req` = 1 in FETCH and DROP; 0 in BUFFERED.
  - `o_imem_addr` = `pc_F` in all states.
- Memory protocol: once `o_imem_req` is raised, the address stays stable and the request stays high until the cycle with `i_imem_ack`=1. A handshake is `o_imem_req & i_imem_ack`.
- NOP = 32'h0000_0013 (addi x0,x0,0).
- FETCH:
  - ack & pcSrc: discard `rdata`; `pc_F` <= `i_pc_target_EX`; stay in FETCH.
  - !ack & pcSrc: `redir_pc` <= `i_pc_target_EX`; go to DROP.
  - ack & `stall_IF` & !pcSrc: `buf` <= {`rdata`, `pc_F`}; `pc_F` += 4; go to BUFFERED.
  - ack & !`stall_IF` & !pcSrc: IF/ID loads the fetched instruction; `pc_F` += 4.
  - !ack & !pcSrc: no change to `pc_F`.
- BUFFERED:
  - pcSrc: drop the buffer; `pc_F` <= target; go to FETCH.
  - !`stall_IF`: IF/ID loads the buffer; go to FETCH.
  - Otherwise hold.
- DROP:
  - pcSrc without ack: `redir_pc` <= new target (the latest redirect wins).
  - ack: discard `rdata`; `pc_F` <= (pcSrc ? `i_pc_target_EX` : `redir_pc`); go to FETCH.
- IF/ID update, in priority order:
  1. `i_flush_ID`: load bubble (`o_instr_ID`=NOP, `o_valid_ID`=0, PCs unchanged).
  2. `i_stall_ID`: hold.
  3. Valid source (FETCH handshake as above, or BUFFERED with `stall_IF`=0): load `{instr, pc, pc+4, 1}`.
  4. No valid source: load bubble.
- Arithmetic:
  - `pc+4` is DATA_WIDTH-bit modulo; 32'hFFFF_FFFC + 4 = 0.
  - `i_pc_target_EX[1:0]` is ignored and forced to 0.

## Timing
- Reset (asynchronous assert, synchronous-to-clock deassert handled upstream):
  - State FETCH, `pc_F`=RESET_PC.
  - `o_imem_req`=0 while `i_rst_n`=0.
  - `o_instr_ID`=NOP, `o_pc_ID`=0, `o_pc_plus4_ID`=0, `o_valid_ID`=0.
  - Buffer empty; `redir_pc`=0.
- First cycle after release: `o_imem_req`=1, `o_imem_addr`=RESET_PC.
- Fetch latency with a zero-wait memory: ack in cycle N → `o_instr_ID` valid from edge N+1. Throughput is 1 instruction/cycle.
- Redirect in cycle N: the first fetch of the target is issued in cycle N+1 (or the cycle after the DROP ack). IF/ID is a bubble at N+1, via the hazard unit's `flush_ID`.
- Stall released in cycle N from BUFFERED: the buffered instruction appears in IF/ID at N+1; a request for `pc_F` is issued at N+1.
- Reset asserted mid-transaction: the outstanding fetch is abandoned, and its late ack is ignored (`o_imem_req`=0).
- `pcSrc` & `stall_IF` in the same cycle: the redirect wins.
- `flush_ID` & `stall_ID` in the same cycle: the flush wins.

## Test plan
- Reset, zero-wait memory returning `rdata`=addr|0x13 → IF/ID `o_pc_ID` sequence 0x0, 0x4, 0x8 on consecutive cycles; `o_valid_ID`=1 from the 2nd edge.
- Ack for 0x8 with `stall_IF`=`stall_ID`=1 for 3 cycles → `o_imem_req`=0 during the stall; IF/ID holds 0x4. Release → IF/ID = {0x8 instr, 0x8, 0xC}; next request at 0xC.
- Memory with 2 wait states; `pcSrc`=1 with target 0x100 in the first wait cycle → `o_imem_addr` stays at 0x10 until ack; `rdata` discarded; next request at 0x100; no instruction from 0x10 ever reaches `o_valid_ID`=1.
- Two redirects during one outstanding fetch (0x100, then 0x200) → after the ack, the fetch is at 0x200.
- `flush_ID`=1 and `stall_ID`=1 together → `o_instr_ID`=0x00000013, `o_valid_ID`=0.
- Reset asserted while in BUFFERED with `o_imem_req` low → all outputs return to their reset values immediately; after release, the fetch restarts at RESET_PC.

Source files
------------

// File: rtl/fetch_unit.sv
// fetch_unit -- instruction-fetch stage and IF/ID pipeline register.
//
// Owns the fetch PC and drives a req/ack instruction-memory port. If an
// instruction returns while the fetch stage is stalled, it is held in a
// one-entry skid buffer. Fetches that are still in flight when a redirect
// arrives are discarded. The decode stage sees {instr, pc, pc+4, valid}.
//
// Ports:
//   i_clk, i_rst_n          clock, asynchronous active-low reset
//   i_stall_IF              hold the fetch PC (hazard unit)
//   i_stall_ID              hold the IF/ID register (hazard unit)
//   i_flush_ID              load a bubble into IF/ID (hazard unit)
//   i_pcSrc_EX              taken branch/jump resolved in EX
//   i_pc_target_EX          redirect target (bits [1:0] ignored)
//   o_imem_req, o_imem_addr instruction-memory request and word address
//   i_imem_ack, i_imem_rdata memory response (ack may be same-cycle)
//   o_instr_ID, o_pc_ID, o_pc_plus4_ID, o_valid_ID  IF/ID register
module fetch_unit #(
  parameter int unsigned              DATA_WIDTH = 32,
  parameter logic [DATA_WIDTH-1:0]    RESET_PC   = '0
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_stall_IF,
  input  logic                  i_stall_ID,
  input  logic                  i_flush_ID,
  input  logic                  i_pcSrc_EX,
  input  logic [DATA_WIDTH-1:0] i_pc_target_EX,
  output logic                  o_imem_req,
  output logic [DATA_WIDTH-1:0] o_imem_addr,
  input  logic                  i_imem_ack,
  input  logic [DATA_WIDTH-1:0] i_imem_rdata,
  output logic [DATA_WIDTH-1:0] o_instr_ID,
  output logic [DATA_WIDTH-1:0] o_pc_ID,
  output logic [DATA_WIDTH-1:0] o_pc_plus4_ID,
  output logic                  o_valid_ID
);

  localparam logic [DATA_WIDTH-1:0] NOP        = DATA_WIDTH'(32'h0000_0013);
  localparam logic [DATA_WIDTH-1:0] ALIGN_MASK = ~DATA_WIDTH'(3);
  localparam logic [DATA_WIDTH-1:0] PC_STEP    = DATA_WIDTH'(4);

  typedef enum logic [1:0] {
    FETCH    = 2'd0,
    BUFFERED = 2'd1,
    DROP     = 2'd2
  } state_t;

  state_t                  state, state_n;
  logic [DATA_WIDTH-1:0]   pc_F, pc_F_n;
  logic [DATA_WIDTH-1:0]   redir_pc, redir_pc_n;
  logic [DATA_WIDTH-1:0]   buf_instr, buf_pc;
  logic                    buf_load;

  logic [DATA_WIDTH-1:0]   target;
  logic                    handshake;
  logic                    src_valid;
  logic [DATA_WIDTH-1:0]   src_instr, src_pc;

  assign target = i_pc_target_EX & ALIGN_MASK;

  // Request is gated by reset so nothing is issued, and no late ack is
  // honoured, while the core is held in reset.
  assign o_imem_req  = i_rst_n & (state != BUFFERED);
  assign o_imem_addr = pc_F;
  assign handshake   = o_imem_req & i_imem_ack;

  always_comb begin
    state_n    = state;
    pc_F_n     = pc_F;
    redir_pc_n = redir_pc;
    buf_load   = 1'b0;
    src_valid  = 1'b0;
    src_instr  = i_imem_rdata;
    src_pc     = pc_F;
    unique case (state)
      FETCH: begin
        if (i_pcSrc_EX) begin
          // A redirect always wins over stall; an unfinished fetch must be
          // completed (address held) and then thrown away in DROP.
          if (handshake) begin
            pc_F_n = target;
          end else begin
            redir_pc_n = target;
            state_n    = DROP;
          end
        end else if (handshake) begin
          pc_F_n = pc_F + PC_STEP;
          if (i_stall_IF) begin
            buf_load = 1'b1;
            state_n  = BUFFERED;
          end else begin
            src_valid = 1'b1;
          end
        end
      end
      BUFFERED: begin
        if (i_pcSrc_EX) begin
          pc_F_n  = target;
          state_n = FETCH;
        end else if (!i_stall_IF) begin
          src_valid = 1'b1;
          src_instr = buf_instr;
          src_pc    = buf_pc;
          state_n   = FETCH;
        end
      end
      DROP: begin
        if (handshake) begin
          pc_F_n  = i_pcSrc_EX ? target : redir_pc;
          state_n = FETCH;
        end else if (i_pcSrc_EX) begin
          redir_pc_n = target;
        end
      end
      default: state_n = FETCH;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state     <= FETCH;
      pc_F      <= RESET_PC & ALIGN_MASK;
      redir_pc  <= '0;
      buf_instr <= '0;
      buf_pc    <= '0;
    end else begin
      state    <= state_n;
      pc_F     <= pc_F_n;
      redir_pc <= redir_pc_n;
      if (buf_load) begin
        buf_instr <= i_imem_rdata;
        buf_pc    <= pc_F;
      end
    end
  end

  // IF/ID register: flush beats stall; a bubble keeps the previous PCs.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_instr_ID    <= NOP;
      o_pc_ID       <= '0;
      o_pc_plus4_ID <= '0;
      o_valid_ID    <= 1'b0;
    end else if (i_flush_ID) begin
      o_instr_ID <= NOP;
      o_valid_ID <= 1'b0;
    end else if (!i_stall_ID) begin
      if (src_valid) begin
        o_instr_ID    <= src_instr;
        o_pc_ID       <= src_pc;
        o_pc_plus4_ID <= src_pc + PC_STEP;
        o_valid_ID    <= 1'b1;
      end else begin
        o_instr_ID <= NOP;
        o_valid_ID <= 1'b0;
      end
    end
  end

endmodule
